// File: rtl/p09_block_state_ctrl_pkg.sv
// p09_block_state_ctrl_pkg: shared geometry, FSM encoding and counter limits
package p09_block_state_ctrl_pkg;
    localparam int BLOCKS_PER_ROW = 13;
    localparam int NUM_ROWS = 15;
    localparam int CNT_W = 4;
    localparam logic [7:0] MAX_BLOCKS = 8'd195;
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/p09_popcount13.sv
// p09_popcount13: counts set bits of a 13-bit word (used for cleared blocks)
module p09_popcount13
    import p09_block_state_ctrl_pkg::*;
(
    input  logic [12:0]      i_bits,
    output logic [CNT_W-1:0] o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < 13; i++) o_count = o_count + CNT_W'(i_bits[i]);
    end
endmodule

// File: rtl/p09_block_state_ctrl.sv
// p09_block_state_ctrl: per-row block bitmap with refill FSM and remaining-block counter
module p09_block_state_ctrl #(
    parameter int BLOCKS_PER_ROW = p09_block_state_ctrl_pkg::BLOCKS_PER_ROW,
    parameter int NUM_ROWS = p09_block_state_ctrl_pkg::NUM_ROWS
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      new_frame,
    input  logic                      go_next_line,
    input  logic                      write_block_line_state,
    input  logic [BLOCKS_PER_ROW-1:0] new_block_line_state,
    input  logic                      level_start,
    output logic [BLOCKS_PER_ROW-1:0] block_line_state,
    output logic [7:0]                blocks_remaining,
    output logic                      init_busy,
    output logic                      level_clear
);
    import p09_block_state_ctrl_pkg::*;
    localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);
    state_t r_state, w_state_next;
    logic [BLOCKS_PER_ROW-1:0] r_rows [NUM_ROWS];
    logic [3:0] r_row_ptr, r_init_row, w_ptr_next;
    logic [7:0] r_remaining, w_remaining_next;
    logic r_level_clear, w_write, w_init_wr, w_init_done;
    logic [BLOCKS_PER_ROW-1:0] w_old, w_new;
    logic [CNT_W-1:0] w_cleared;
    assign w_old = r_rows[r_row_ptr];
    assign w_new = w_old & new_block_line_state;
    p09_popcount13 u_pop (.i_bits(w_old & ~w_new), .o_count(w_cleared));
    always_ff @(posedge clk) r_state <= !nRst ? ST_INIT : w_state_next;
    always_comb begin
        w_init_done = r_state == ST_INIT && r_init_row == LAST_ROW && !level_start;
        w_init_wr = r_state == ST_INIT && !level_start;
        w_write = r_state == ST_RUN && write_block_line_state && !level_start;
        w_state_next = level_start ? ST_INIT : w_init_done ? ST_RUN : r_state;
        w_ptr_next = new_frame ? 4'd0 : !go_next_line ? r_row_ptr :
                     r_row_ptr == LAST_ROW ? 4'd0 : r_row_ptr + 4'd1;
        // saturate so a cleared-bit count can never wrap the counter
        w_remaining_next = w_write ? ({4'd0, w_cleared} > r_remaining ? 8'd0 : r_remaining - {4'd0, w_cleared}) :
                           w_init_done ? MAX_BLOCKS : r_remaining;
        init_busy = r_state == ST_INIT;
    end
    always_ff @(posedge clk) begin
        if (!nRst) begin
            for (int i = 0; i < NUM_ROWS; i++) r_rows[i] <= '0;
            r_row_ptr <= '0;
            r_init_row <= '0;
            r_remaining <= '0;
            r_level_clear <= 1'b0;
        end else begin
            r_row_ptr <= w_ptr_next;
            r_remaining <= w_remaining_next;
            r_level_clear <= w_write && r_remaining != 8'd0 && w_remaining_next == 8'd0;
            r_init_row <= level_start ? 4'd0 : r_state == ST_INIT ? r_init_row + 4'd1 : r_init_row;
            if (w_init_wr) r_rows[r_init_row] <= '1;
            if (w_write) r_rows[r_row_ptr] <= w_new;
        end
    end
    assign block_line_state = w_old;
    assign blocks_remaining = r_remaining;
    assign level_clear = r_level_clear;
endmodule

// File: tb/tb_p09_block_state_ctrl.sv
// tb_p09_block_state_ctrl: scoreboard bench for the block state controller
module tb_p09_block_state_ctrl;
    localparam int NR = 15;
    logic clk = 1'b0, nRst = 1'b0, new_frame = 1'b0, go_next_line = 1'b0;
    logic write_block_line_state = 1'b0, level_start = 1'b0;
    logic [12:0] new_block_line_state = '0, block_line_state;
    logic [7:0] blocks_remaining;
    logic init_busy, level_clear;
    typedef struct {string tag; logic [12:0] line; logic [7:0] rem; logic clr;} exp_t;
    exp_t sb[$];
    int n_tests = 0, n_fail = 0, clear_cnt = 0, m_ptr = 0, m_rem = 0, n;
    logic [12:0] m_rows [NR];
    always #5 clk = ~clk;
    always @(negedge clk) if (level_clear) clear_cnt++;
    p09_block_state_ctrl #(.BLOCKS_PER_ROW(13), .NUM_ROWS(15)) dut (
        .clk(clk), .nRst(nRst), .new_frame(new_frame), .go_next_line(go_next_line),
        .write_block_line_state(write_block_line_state), .new_block_line_state(new_block_line_state),
        .level_start(level_start), .block_line_state(block_line_state),
        .blocks_remaining(blocks_remaining), .init_busy(init_busy), .level_clear(level_clear)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic op(input string tag, input logic wr, input logic [12:0] d, input logic gnl, input logic nf);
        exp_t e;
        logic [12:0] nw;
        int old;
        write_block_line_state = wr;
        new_block_line_state = d;
        go_next_line = gnl;
        new_frame = nf;
        old = m_rem;
        if (wr) begin
            nw = m_rows[m_ptr] & d;
            m_rem -= $countones(m_rows[m_ptr] & ~nw);
            m_rows[m_ptr] = nw;
        end
        m_ptr = nf ? 0 : !gnl ? m_ptr : m_ptr == NR - 1 ? 0 : m_ptr + 1;
        e.tag = tag;
        e.line = m_rows[m_ptr];
        e.rem = 8'(m_rem);
        e.clr = old != 0 && m_rem == 0;
        sb.push_back(e);
        tick;
        write_block_line_state = 1'b0;
        go_next_line = 1'b0;
        new_frame = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_line"}, 32'(block_line_state), 32'(e.line));
        check({e.tag, "_rem"}, 32'(blocks_remaining), 32'(e.rem));
        check({e.tag, "_clr"}, 32'(level_clear), 32'(e.clr));
    endtask
    task automatic refill_wait(input string tag);
        int k = 0;
        while (init_busy && k < 100) begin
            tick;
            k++;
        end
        check(tag, k, 15);
        for (int i = 0; i < NR; i++) m_rows[i] = 13'h1FFF;
        m_rem = 195;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        repeat (3) tick;
        check("rst_rem", 32'(blocks_remaining), 0);
        check("rst_line", 32'(block_line_state), 0);
        check("rst_clr", 32'(level_clear), 0);
        check("rst_busy", 32'(init_busy), 1);
        nRst = 1'b1;
        refill_wait("init_cycles");
        check("init_rem", 32'(blocks_remaining), 195);
        check("init_clr", 32'(level_clear), 0);
        check("row0_ones", 32'(block_line_state), 32'h1FFF);
        for (int i = 0; i < NR; i++) op("row_ones", 1'b0, '0, 1'b1, 1'b0);
        repeat (3) op("to_row3", 1'b0, '0, 1'b1, 1'b0);
        op("wr_clear_bit", 1'b1, 13'h1FFB, 1'b0, 1'b0);
        check("row3_1ffb", 32'(block_line_state), 32'h1FFB);
        check("rem_194", 32'(blocks_remaining), 194);
        op("wr_no_set", 1'b1, 13'h1FFF, 1'b0, 1'b0);
        for (int i = 0; i < NR; i++) op("wr_gnl", 1'b1, 13'($urandom) | 13'h0100, 1'b1, 1'b0);
        op("nf_gnl", 1'b0, '0, 1'b1, 1'b1);
        op("gnl", 1'b0, '0, 1'b1, 1'b0);
        op("nf", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < NR + 1; i++) op("wrap_walk", 1'b0, '0, 1'b1, 1'b0);
        op("wr_nf", 1'b1, 13'h1EFF, 1'b0, 1'b1);
        for (int i = 0; i < NR; i++) op("clr_all", 1'b1, '0, 1'b1, 1'b0);
        check("rem_zero", 32'(blocks_remaining), 0);
        repeat (3) op("idle", 1'b0, '0, 1'b0, 1'b0);
        op("wr_at_zero", 1'b1, '0, 1'b0, 1'b0);
        check("clear_pulses", clear_cnt, 1);
        level_start = 1'b1;
        tick;
        level_start = 1'b0;
        check("ls_busy", 32'(init_busy), 1);
        write_block_line_state = 1'b1;
        new_block_line_state = '0;
        repeat (7) tick;
        check("init_rem_hold", 32'(blocks_remaining), 0);
        level_start = 1'b1;
        tick;
        level_start = 1'b0;
        refill_wait("restart_cycles");
        write_block_line_state = 1'b0;
        check("restart_rem", 32'(blocks_remaining), 195);
        for (int i = 0; i < NR; i++) op("refill_row", 1'b0, '0, 1'b1, 1'b0);
        check("no_clr_in_init", clear_cnt, 1);
        op("pre_rst", 1'b1, 13'h0F0F, 1'b0, 1'b0);
        nRst = 1'b0;
        tick;
        check("midrun_rst_rem", 32'(blocks_remaining), 0);
        check("midrun_rst_line", 32'(block_line_state), 0);
        check("midrun_rst_busy", 32'(init_busy), 1);
        nRst = 1'b1;
        m_ptr = 0;
        refill_wait("rst_run_cycles");
        check("rst_run_rem", 32'(blocks_remaining), 195);
        check("rst_run_line", 32'(block_line_state), 32'h1FFF);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/p09_block_state_ctrl.md
P09_BLOCK_STATE_CTRL -- requirements
Module: p09_block_state_ctrl

Interface
REQ-001 SHALL have parameter BLOCKS_PER_ROW, default 13, number of blocks per row (bits per row word).
REQ-002 SHALL have parameter NUM_ROWS, default 15, number of block rows stored.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 nRst  input  1  reset; synchronous, active-low, sampled on rising clk.
REQ-005 new_frame  input  1  one-cycle pulse at frame start; rewinds read row pointer.
REQ-006 go_next_line  input  1  one-cycle pulse; advance read row pointer.
REQ-007 write_block_line_state  input  1  one-cycle write strobe for the current row.
REQ-008 new_block_line_state  input  BLOCKS_PER_ROW  updated row word from painter.
REQ-009 level_start  input  1  one-cycle pulse; refill all rows and restart the level.
REQ-010 block_line_state  output  BLOCKS_PER_ROW  row word at the current row pointer.
REQ-011 blocks_remaining  output  8  count of set bits across all rows.
REQ-012 init_busy  output  1  high while the refill sequence runs.
REQ-013 level_clear  output  1  one-cycle pulse when blocks_remaining reaches 0.

Function
REQ-014 SHALL hold NUM_ROWS row registers, each BLOCKS_PER_ROW wide, plus row_ptr (4 bit) and init_row (4 bit).
REQ-015 SHALL drive block_line_state combinationally from rows[row_ptr].
REQ-016 SHALL implement a two-state FSM: INIT, RUN.
REQ-017 INIT: each cycle, write all-ones to rows[init_row] and increment init_row; after writing row NUM_ROWS-1, go to RUN with blocks_remaining = NUM_ROWS*BLOCKS_PER_ROW (195). Total is exactly NUM_ROWS cycles.
REQ-018 INIT: init_busy = 1; painter writes are ignored and blocks_remaining is not updated.
REQ-019 level_start in any state: init_row <= 0, state <= INIT, and the refill restarts from row 0.
REQ-020 RUN: on write_block_line_state, rows[row_ptr] <= rows[row_ptr] & new_block_line_state. Writes can only clear bits.
REQ-021 RUN write: blocks_remaining decrements by popcount(old & ~new) in the same cycle. The new value is visible on the next cycle.
REQ-022 Write latency: data written in cycle N SHALL appear on block_line_state in cycle N+1 when row_ptr is unchanged.
REQ-023 go_next_line: row_ptr increments; at NUM_ROWS-1 it wraps to 0.
REQ-024 new_frame: row_ptr <= 0.
REQ-025 new_frame together with go_next_line: new_frame wins.
REQ-026 A write in the same cycle as go_next_line or new_frame SHALL target the pre-update row_ptr.
REQ-027 row_ptr SHALL update in both INIT and RUN.
REQ-028 level_clear SHALL pulse for one cycle in RUN on the cycle after blocks_remaining changes from nonzero to 0.
REQ-029 level_clear SHALL NOT repeat while the count stays 0, and SHALL NOT fire in INIT.
REQ-030 blocks_remaining SHALL never underflow; the decrement is applied only to bits that were set.

Reset
REQ-031 While nRst = 0 at a clk edge: all rows <= 0, row_ptr <= 0, init_row <= 0, blocks_remaining <= 0, level_clear <= 0, state <= INIT.
REQ-032 Consequence of REQ-031: after reset release the refill runs automatically; init_busy = 1 starting in the first cycle after release.
REQ-033 Reset asserted mid-INIT or mid-RUN SHALL discard all progress and return to REQ-031 values.

Structure
REQ-034 The shared package SHALL hold BLOCKS_PER_ROW, NUM_ROWS, the FSM state encoding (INIT=0, RUN=1) and MAX_BLOCKS = 195.
REQ-035 The block SHALL use one sub-module, p09_popcount13: combinational, 13-bit in, 4-bit out, counting cleared bits.
REQ-036 Target size: 120-400 lines of RTL; no memories inferred, flops only.

Verification
REQ-037 Reset: release reset -> init_busy high for exactly 15 cycles, then blocks_remaining = 195, every row reads 13'h1FFF, level_clear = 0.
REQ-038 Write: row_ptr = 3 and rows[3] = 13'h1FFF, write 13'h1FFB -> next cycle block_line_state = 13'h1FFB and blocks_remaining = 194.
REQ-039 Write cannot set bits: rows[3] = 13'h1FFB, write 13'h1FFF -> row stays 13'h1FFB, count unchanged.
REQ-040 Pointer: 15 go_next_line pulses from row 0 -> row_ptr returns to 0. new_frame and go_next_line together -> row_ptr = 0.
REQ-041 Clear all 195 blocks with writes of 13'h0000 on each row -> blocks_remaining = 0 and exactly one level_clear pulse.
REQ-042 Restart: level_start during INIT at row 7 -> refill restarts from row 0 and init_busy lasts 15 more cycles. Writes during INIT -> no effect.
